add_sub_pipe: RTL and testbench



---
 rtl/add_sub_pipe.sv | 141 ++++++++++++++
 tb/tb_add_sub_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_pipe.sv
// ---------------------------------------------------------------------------
// add_sub_pipe
//
// A pipelined adder/subtractor that uses a valid/ready handshake. The operand
// word is divided into STAGES chunks of CW = WIDTH/STAGES bits. Each pipeline
// rank resolves the carry chain of one chunk. This keeps the critical path at
// one CW-bit adder, whatever the value of WIDTH.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset (clears control and data)
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (= advance && !rst)
//   a, b       operands, WIDTH bits
//   do_sub     0: s = a + b, 1: s = a - b
//   out_valid  result beat present
//   out_ready  downstream takes the result this cycle
//   s          result modulo 2^WIDTH
//   c          carry out of the MSB (for subtract, 1 = no borrow)
//   v          signed two's-complement overflow
//   z          s == 0
//   n          s[WIDTH-1]
// ---------------------------------------------------------------------------
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             do_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int CW  = WIDTH / STAGES;
    localparam int L   = STAGES - 1;
    // Ranks 0..STAGES-2 carry the not-yet-added upper operand bits forward.
    // The last rank has no further chunks, so it needs no operand storage.
    localparam int OPN = (STAGES > 1) ? STAGES - 1 : 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("add_sub_pipe: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic             w_en;
    logic [WIDTH-1:0] w_bx;
    logic [CW:0]      w_chunk [STAGES];
    logic [WIDTH-1:0] w_resn  [STAGES];

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_cy;
    logic [STAGES-1:0] r_zf;
    logic [STAGES-1:0] r_amsb;
    logic [STAGES-1:0] r_bmsb;
    logic [WIDTH-1:0]  r_res [STAGES];
    // r_a[k] / r_b[k] hold the operands shifted right by (k+1)*CW. The next
    // rank's chunk is therefore always the low CW bits.
    logic [WIDTH-1:0]  r_a [OPN];
    logic [WIDTH-1:0]  r_b [OPN];

    // Every rank either shifts together or holds together. Bubbles are not
    // collapsed, so the stall signal is a single gate from out_ready.
    assign w_en     = !r_vld[L] || out_ready;
    assign in_ready = w_en && !rst;

    // Subtraction is computed as a + ~b + 1 in a single chain. This keeps c
    // correct when b == 0.
    assign w_bx = b ^ {WIDTH{do_sub}};

    for (genvar g = 0; g < STAGES; g++) begin : g_rank
        if (g == 0) begin : g_first
            assign w_chunk[0] = {1'b0, a[CW-1:0]} + {1'b0, w_bx[CW-1:0]}
                              + {{CW{1'b0}}, do_sub};
            assign w_resn[0]  = WIDTH'(w_chunk[0][CW-1:0]);
        end else begin : g_next
            assign w_chunk[g] = {1'b0, r_a[g-1][CW-1:0]} + {1'b0, r_b[g-1][CW-1:0]}
                              + {{CW{1'b0}}, r_cy[g-1]};
            // The result chunks above rank g-1 are still zero, so OR-ing
            // inserts the new chunk.
            assign w_resn[g]  = r_res[g-1] | (WIDTH'(w_chunk[g][CW-1:0]) << (g * CW));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_cy   <= '0;
            r_zf   <= '0;
            r_amsb <= '0;
            r_bmsb <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_res[k] <= '0;
            end
            for (int k = 0; k < OPN; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (w_en) begin
            // rank 0: load from the ports and resolve chunk 0
            r_vld[0]  <= in_valid;
            r_res[0]  <= w_resn[0];
            r_cy[0]   <= w_chunk[0][CW];
            r_zf[0]   <= (w_chunk[0][CW-1:0] == '0);
            r_amsb[0] <= a[WIDTH-1];
            r_bmsb[0] <= w_bx[WIDTH-1];
            r_a[0]    <= a >> CW;
            r_b[0]    <= w_bx >> CW;
            // rank k: resolve chunk k using the carry from rank k-1
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_res[k]  <= w_resn[k];
                r_cy[k]   <= w_chunk[k][CW];
                r_zf[k]   <= r_zf[k-1] && (w_chunk[k][CW-1:0] == '0);
                r_amsb[k] <= r_amsb[k-1];
                r_bmsb[k] <= r_bmsb[k-1];
            end
            for (int k = 1; k < OPN; k++) begin
                r_a[k] <= r_a[k-1] >> CW;
                r_b[k] <= r_b[k-1] >> CW;
            end
        end
    end

    // last rank drives the outputs
    assign out_valid = r_vld[L];
    assign s         = r_res[L];
    assign c         = r_cy[L];
    assign z         = r_zf[L];
    assign n         = r_res[L][WIDTH-1];
    assign v         = (r_amsb[L] == r_bmsb[L]) && (r_res[L][WIDTH-1] != r_amsb[L]);

endmodule

// File: tb/tb_add_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_add_sub_pipe
//
// Self-checking bench for add_sub_pipe. It instantiates four configurations,
// (32,4), (8,1), (16,2) and (64,8), which share clock, reset and stimulus.
// Operands are truncated to each width.
// ---------------------------------------------------------------------------
module tb_add_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        do_sub;
    logic [63:0] a_in;
    logic [63:0] b_in;

    logic [3:0]  ir_x, ov_x, c_x, v_x, z_x, n_x;
    logic [31:0] s0;
    logic [7:0]  s1;
    logic [15:0] s2;
    logic [63:0] s3;

    int errors = 0;
    int checks = 0;

    localparam int W_OF  [4] = '{32, 8, 16, 64};
    localparam int ST_OF [4] = '{4, 1, 2, 8};

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(32), .STAGES(4)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_x[0]),
        .a(a_in[31:0]), .b(b_in[31:0]), .do_sub(do_sub),
        .out_valid(ov_x[0]), .out_ready(out_ready),
        .s(s0), .c(c_x[0]), .v(v_x[0]), .z(z_x[0]), .n(n_x[0]));

    add_sub_pipe #(.WIDTH(8), .STAGES(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_x[1]),
        .a(a_in[7:0]), .b(b_in[7:0]), .do_sub(do_sub),
        .out_valid(ov_x[1]), .out_ready(out_ready),
        .s(s1), .c(c_x[1]), .v(v_x[1]), .z(z_x[1]), .n(n_x[1]));

    add_sub_pipe #(.WIDTH(16), .STAGES(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_x[2]),
        .a(a_in[15:0]), .b(b_in[15:0]), .do_sub(do_sub),
        .out_valid(ov_x[2]), .out_ready(out_ready),
        .s(s2), .c(c_x[2]), .v(v_x[2]), .z(z_x[2]), .n(n_x[2]));

    add_sub_pipe #(.WIDTH(64), .STAGES(8)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_x[3]),
        .a(a_in), .b(b_in), .do_sub(do_sub),
        .out_valid(ov_x[3]), .out_ready(out_ready),
        .s(s3), .c(c_x[3]), .v(v_x[3]), .z(z_x[3]), .n(n_x[3]));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    // {s, c, v, z, n} of one configuration, zero-extended to 64-bit s
    function automatic logic [67:0] got(input int sel);
        logic [63:0] sv;
        case (sel)
            0:       sv = 64'(s0);
            1:       sv = 64'(s1);
            2:       sv = 64'(s2);
            default: sv = s3;
        endcase
        return {sv, c_x[sel], v_x[sel], z_x[sel], n_x[sel]};
    endfunction

    // Reference model: plain wide arithmetic with textbook flag definitions
    function automatic logic [67:0] model(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic sub);
        logic [63:0] mask, aa, bb, sv;
        logic [64:0] wide;
        logic        cv, vv, sa, sb, ss;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa   = av & mask;
        bb   = bv & mask;
        if (!sub) begin
            wide = {1'b0, aa} + {1'b0, bb};
            sv   = wide[63:0] & mask;
            cv   = (wide >> w) != 65'd0;
        end else begin
            sv = (aa - bb) & mask;
            cv = (aa >= bb);
        end
        sa = aa[w-1];
        sb = bb[w-1];
        ss = sv[w-1];
        vv = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return {sv, cv, vv, (sv == 64'd0), ss};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one beat with out_ready high. Returns the result and the latency
    // in edges, counted from the accept edge (-1 if nothing emerged).
    task automatic run_beat(input int sel, input logic [63:0] av, input logic [63:0] bv,
                            input logic sub, output logic [67:0] res, output int lat);
        @(negedge clk);
        a_in      = av;
        b_in      = bv;
        do_sub    = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!ov_x[sel] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = got(sel);
        if (!ov_x[sel]) lat = -1;
    endtask

    task automatic stream(input int sel);
        logic [67:0] q[$];
        logic [63:0] ba [16];
        logic [63:0] bb [16];
        logic        bs [16];
        logic [68:0] held;
        logic        stall, acc;
        int          sent, got_n, cyc, extra;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ba[i] = {$urandom, $urandom};
            bb[i] = {$urandom, $urandom};
            bs[i] = 1'($urandom_range(0, 1));
        end
        sent  = 0;
        got_n = 0;
        cyc   = 0;
        while (got_n < 16 && cyc < 400) begin
            @(negedge clk);
            out_ready = (cyc >= 6 && cyc < 11) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (sent < 16) begin
                in_valid = 1'b1;
                a_in     = ba[sent];
                b_in     = bb[sent];
                do_sub   = bs[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk($sformatf("in_ready_rule%0d", sel), 128'(ir_x[sel]),
                128'(!(ov_x[sel] && !out_ready)));
            acc = in_valid && ir_x[sel];
            if (ov_x[sel] && out_ready) begin
                if (q.size() == 0) chk($sformatf("stream_extra%0d", sel), 128'(got(sel)), 128'(0));
                else chk($sformatf("stream_data%0d", sel), 128'(got(sel)), 128'(q.pop_front()));
                got_n++;
            end
            if (acc) begin
                q.push_back(model(W_OF[sel], ba[sent], bb[sent], bs[sent]));
                sent++;
            end else if (in_valid) begin
                // An operand that is not accepted must not leak into the pipeline.
                a_in = ~a_in;
                b_in = ~b_in;
            end
            stall = ov_x[sel] && !out_ready;
            held  = {ov_x[sel], got(sel)};
            @(posedge clk);
            #1;
            if (stall) chk($sformatf("stall_hold%0d", sel), 128'({ov_x[sel], got(sel)}), 128'(held));
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk($sformatf("stream_count%0d", sel), 128'(got_n), 128'(16));
        chk($sformatf("stream_left%0d", sel), 128'(q.size()), 128'(0));
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ov_x[sel]) extra++;
        end
        chk($sformatf("stream_dup%0d", sel), 128'(extra), 128'(0));
    endtask

    initial begin
        vec_t        tbl [12];
        logic [67:0] res;
        logic [63:0] m, lo;
        int          lat;

        tbl[0]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{32'h00000007, 32'h00000000, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        do_sub    = 1'b0;
        a_in      = '0;
        b_in      = '0;
        do_reset();

        // reset state of every configuration
        #1;
        for (int sel = 0; sel < 4; sel++) begin
            chk($sformatf("reset_out%0d", sel), 128'({ov_x[sel], got(sel)}), 128'(0));
            chk($sformatf("reset_ready%0d", sel), 128'(ir_x[sel]), 128'(1));
        end

        // hand-computed vectors on the default configuration
        for (int i = 0; i < 12; i++) begin
            run_beat(0, {32'd0, tbl[i].a}, {32'd0, tbl[i].b}, tbl[i].sub, res, lat);
            chk($sformatf("vec%0d", i), 128'(res),
                128'({32'd0, tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n}));
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(4));
        end

        // width-relative corner cases across all configurations
        for (int sel = 0; sel < 4; sel++) begin
            logic [63:0] va [7];
            logic [63:0] vb [7];
            logic        vs [7];
            do_reset();
            m  = (W_OF[sel] == 64) ? '1 : ((64'd1 << W_OF[sel]) - 64'd1);
            lo = (64'd1 << (W_OF[sel] / 2)) - 64'd1;
            va = '{lo, 64'd7, 64'd3, 64'd7, m >> 1, ~(m >> 1) & m, m};
            vb = '{64'd1, 64'd7, 64'd5, 64'd0, 64'd1, 64'd1, 64'd1};
            vs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 7; i++) begin
                run_beat(sel, va[i], vb[i], vs[i], res, lat);
                chk($sformatf("sweep%0d_v%0d", sel, i), 128'(res),
                    128'(model(W_OF[sel], va[i], vb[i], vs[i])));
                chk($sformatf("sweep%0d_lat%0d", sel, i), 128'(lat), 128'(ST_OF[sel]));
            end
        end

        // streaming with backpressure on every configuration
        for (int sel = 0; sel < 4; sel++) stream(sel);

        // reset with three beats in flight
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_in     = 64'(100 + i);
            b_in     = 64'd1;
            do_sub   = 1'b0;
        end
        @(negedge clk);
        rst      = 1'b1;
        a_in     = 64'd100;
        b_in     = 64'd100;
        #1;
        chk("rst_in_ready", 128'(ir_x[0]), 128'(0));
        @(posedge clk);
        #1;
        chk("rst_flush", 128'({ov_x[0], got(0)}), 128'(0));
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_release_ready", 128'(ir_x[0]), 128'(1));
        run_beat(0, 64'd5, 64'd3, 1'b0, res, lat);
        chk("rst_fresh", 128'(res), 128'({64'd8, 1'b0, 1'b0, 1'b0, 1'b0}));
        chk("rst_fresh_lat", 128'(lat), 128'(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
